// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl
//   Fetch sequencer for a word-addressed, single-port instruction memory.
//   Owns the program counter, issues at most one read per cycle, captures
//   each returned word together with its PC in a small FIFO, and presents
//   the FIFO head to decode over a valid/ready handshake. A branch redirect
//   flushes buffered and in-flight words and restarts fetch at the new PC.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   en              fetch enable (high = run, low = stop issuing)
//   im_addr, im_rd  read address (the PC register) and read strobe
//   im_instr        read data, valid the cycle after im_rd
//   redirect_valid  one-cycle request to load redirect_pc
//   redirect_pc     redirect target PC
//   out_valid       FIFO head valid
//   out_instr       FIFO head instruction (zero when out_valid=0)
//   out_pc          FIFO head PC (zero when out_valid=0)
//   out_ready       decode accepts the head when out_valid && out_ready
//   busy            FSM not idle, or FIFO holds words
module im_fetch_ctrl #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] im_addr,
    output logic              im_rd,
    input  logic [DATA_W-1:0] im_instr,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready,
    output logic              busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] pc;

    // Stage p1: a read issued last cycle whose data is on im_instr now.
    logic              vld_p1;
    logic [ADDR_W-1:0] pc_p1;

    logic [DATA_W-1:0] fifo_instr [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              pop;
    logic              push;
    logic [CNT_W-1:0]  credit;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // A returning word is dropped when a redirect lands in the same cycle.
    assign push      = vld_p1 && !redirect_valid;

    // Slots already claimed: buffered words plus the word still in flight,
    // less the one leaving this cycle. Issuing only while this is below the
    // depth guarantees every landing word has room, so no full check on push.
    assign credit = count + CNT_W'(vld_p1) - CNT_W'(pop);

    assign im_addr = pc;
    assign im_rd   = (state == S_RUN) && !redirect_valid
                     && (credit < CNT_W'(FIFO_DEPTH));

    assign out_instr = out_valid ? fifo_instr[rd_ptr] : '0;
    assign out_pc    = out_valid ? fifo_pc[rd_ptr]    : '0;
    assign busy      = (state != S_IDLE) || out_valid;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (en) state_nxt = S_RUN;
            S_RUN:   if (!en) state_nxt = vld_p1 ? S_DRAIN : S_IDLE;
            // The in-flight word lands during DRAIN, so one cycle suffices.
            S_DRAIN: state_nxt = en ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage p0 -> p1: issue, PC advance, FIFO bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            vld_p1 <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                // Flush wins over any concurrent push or pop.
                pc     <= redirect_pc;
                vld_p1 <= 1'b0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (im_rd) pc <= pc + ADDR_W'(1);
                vld_p1 <= im_rd;
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Stage p1 -> FIFO: data registers carry no reset; validity is in control.
    always_ff @(posedge clk) begin
        if (im_rd) pc_p1 <= pc;
        if (push) begin
            fifo_instr[wr_ptr] <= im_instr;
            fifo_pc[wr_ptr]    <= pc_p1;
        end
    end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
module tb_im_fetch_ctrl;

    localparam int DEPTH = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [31:0] im_addr;
    logic        im_rd;
    logic [31:0] im_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready = 1'b1;
    logic        busy;

    int checks = 0;
    int errors = 0;

    im_fetch_ctrl #(
        .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .im_addr(im_addr), .im_rd(im_rd), .im_instr(im_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Instruction memory: word at address a is a+2, one-cycle read latency.
    always_ff @(posedge clk) im_instr <= im_addr + 32'd2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of delivered-to-be words, one outstanding read.
    beat_t       mq[$];
    beat_t       blog[$];
    int          m_state = M_IDLE;
    logic [31:0] m_pc = 32'h0;
    bit          m_inflight = 1'b0;
    logic [31:0] m_ipc = 32'h0;

    function automatic bit model_rd();
        int p;
        p = (mq.size() != 0 && out_ready) ? 1 : 0;
        return (m_state == M_RUN) && !redirect_valid
               && (mq.size() + (m_inflight ? 1 : 0) - p < DEPTH);
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_state = M_IDLE;
                m_pc = 32'h0;
                m_inflight = 1'b0;
                mq.delete();
            end else begin
                bit iss, popm, old_inf;
                int nst;
                iss = model_rd();
                popm = (mq.size() != 0) && out_ready;
                old_inf = m_inflight;
                nst = m_state;
                if (m_state == M_IDLE && en) nst = M_RUN;
                else if (m_state == M_RUN && !en) nst = old_inf ? M_DRAIN : M_IDLE;
                else if (m_state == M_DRAIN) nst = en ? M_RUN : M_IDLE;
                if (redirect_valid) begin
                    mq.delete();
                    m_inflight = 1'b0;
                    m_pc = redirect_pc;
                end else begin
                    if (popm) void'(mq.pop_front());
                    if (m_inflight) begin
                        chk("push_room", 32'(mq.size() < DEPTH), 32'd1);
                        mq.push_back('{m_ipc, m_ipc + 32'd2});
                    end
                    m_inflight = iss;
                    if (iss) begin
                        m_ipc = m_pc;
                        m_pc = m_pc + 32'd1;
                    end
                end
                m_state = nst;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, plus a log of accepted beats.
    initial begin
        forever begin
            logic        e_valid;
            logic [31:0] e_pc, e_instr;
            @(negedge clk);
            e_valid = (mq.size() != 0);
            e_pc    = e_valid ? mq[0].pc : 32'h0;
            e_instr = e_valid ? mq[0].instr : 32'h0;
            chk("cmp_im_rd", im_rd, model_rd());
            chk("cmp_im_addr", im_addr, m_pc);
            chk("cmp_out_valid", out_valid, e_valid);
            chk("cmp_out_pc", out_pc, e_pc);
            chk("cmp_out_instr", out_instr, e_instr);
            chk("cmp_busy", busy, (m_state != M_IDLE) || e_valid);
            if (out_valid && out_ready) blog.push_back('{out_pc, out_instr});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_lpc [12] = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h40, 32'h41,
                                  32'h42, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h1};
    logic [31:0] exp_lin [12] = '{32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h42, 32'h43,
                                  32'h44, 32'h2, 32'h1, 32'h2, 32'h3};

    initial begin
        tick(3);
        chk("rst_im_rd", im_rd, 0);
        chk("rst_im_addr", im_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0; en = 1'b1;                                  // C0
        tick(1); chk("c1_rd", im_rd, 1); chk("c1_addr", im_addr, 0);
        tick(1); chk("c2_addr", im_addr, 1); chk("c2_valid", out_valid, 0);
        tick(1); chk("c3_valid", out_valid, 1); chk("c3_pc", out_pc, 0);
        chk("c3_instr", out_instr, 2); chk("c3_addr", im_addr, 2);
        tick(1); chk("c4_pc", out_pc, 1); chk("c4_instr", out_instr, 3);
        out_ready = 1'b0; #1; chk("c4_stall_rd", im_rd, 0);
        tick(4); chk("c8_pc", out_pc, 1); chk("c8_instr", out_instr, 3);
        chk("c8_rd", im_rd, 0); chk("c8_addr", im_addr, 3); chk("c8_valid", out_valid, 1);
        tick(1); out_ready = 1'b1; #1; chk("c9_rd", im_rd, 1);
        tick(2); chk("c11_pc", out_pc, 3); chk("c11_instr", out_instr, 5);
        tick(1); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
        chk("c12_redir_rd", im_rd, 0);
        tick(1); redirect_valid = 1'b0; #1;
        chk("c13_valid", out_valid, 0); chk("c13_addr", im_addr, 32'h40); chk("c13_rd", im_rd, 1);
        tick(2); chk("c15_pc", out_pc, 32'h40); chk("c15_instr", out_instr, 32'h42);
        en = 1'b0;
        tick(1); chk("c16_drain_rd", im_rd, 0); chk("c16_busy", busy, 1);
        tick(2); chk("c18_busy", busy, 0); chk("c18_valid", out_valid, 0);
        chk("c18_rd", im_rd, 0); chk("c18_addr", im_addr, 32'h43);
        en = 1'b1;
        tick(1); chk("c19_rd", im_rd, 1); chk("c19_addr", im_addr, 32'h43);
        tick(1); #2; rst = 1'b1; #1;
        chk("arst_rd", im_rd, 0); chk("arst_addr", im_addr, 0); chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0); chk("arst_pc", out_pc, 0); chk("arst_instr", out_instr, 0);
        tick(1); rst = 1'b0;                                    // R0
        tick(1); chk("r1_rd", im_rd, 1); chk("r1_addr", im_addr, 0);
        tick(2); chk("r3_pc", out_pc, 0); chk("r3_instr", out_instr, 2);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
        chk("r3_redir_rd", im_rd, 0);
        tick(1); redirect_valid = 1'b0; #1;
        chk("r4_addr", im_addr, 32'hFFFF_FFFF); chk("r4_rd", im_rd, 1);
        tick(1); chk("r5_addr", im_addr, 0); chk("r5_rd", im_rd, 1);
        tick(1); chk("r6_pc", out_pc, 32'hFFFF_FFFF); chk("r6_instr", out_instr, 1);
        tick(1); chk("r7_pc", out_pc, 0); chk("r7_instr", out_instr, 2);
        tick(2);
        chk("log_len", blog.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < blog.size()) begin
                chk($sformatf("log_pc_%0d", i), blog[i].pc, exp_lpc[i]);
                chk($sformatf("log_instr_%0d", i), blog[i].instr, exp_lin[i]);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
